// File: rtl/core_pkg.sv
// Shared opcode, ALU function and FSM state encodings for param_core.
// Pure declarations; no logic, no latency, no backpressure.
package core_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_ALU   = 2'b11;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;
    localparam logic [1:0] FN_NOT = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10
    } state_t;

endpackage

// File: rtl/param_core_if.sv
// Instruction handshake and LED output bundle between source, core and LEDs.
// Wires only; latency and backpressure are defined by the core (inst_ready).
interface param_core_if #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4
);
    localparam int RA_W   = $clog2(NREG);
    localparam int INST_W = 2 + RA_W + DATA_W;

    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] leds;
    logic              led_valid;

    modport master (
        output inst, inst_valid,
        input  inst_ready, leds, led_valid
    );

    modport slave (
        input  inst, inst_valid,
        output inst_ready, leds, led_valid
    );
endinterface

// File: rtl/core_alu.sv
// Combinational ALU: add/sub/and/not with carry-borrow and zero flags.
// Zero latency; no handshake.
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        func,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              z
);
    logic [DATA_W:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = '0;
        c      = 1'b0;
        case (func)
            FN_ADD: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
            end
            FN_SUB: begin
                result = a - b;
                c      = (a < b);
            end
            FN_AND:  result = a & b;
            default: result = ~a;
        endcase
        z = (result == '0);
    end
endmodule

// File: rtl/param_core.sv
// Parametrised fetch/decode/execute register-file core with LED store port.
// 3 cycles per instruction (accept, decode, execute); inst_ready only in FETCH.
module param_core
    import core_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             clr,
    param_core_if.slave      bus,
    output logic             flag_z,
    output logic             flag_c,
    output logic [CNT_W-1:0] retired,
    output logic             busy
);
    localparam int RA_W   = $clog2(NREG);
    localparam int INST_W = 2 + RA_W + DATA_W;

    state_t            state;
    logic [INST_W-1:0] inst_q;
    logic [1:0]        op_q;
    logic [RA_W-1:0]   rx_q;
    logic [1:0]        func_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] leds_q;
    logic              led_valid_q;

    logic [RA_W-1:0]   rx_d;
    logic [RA_W-1:0]   ry_d;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;

    assign rx_d = inst_q[DATA_W +: RA_W];
    assign ry_d = inst_q[DATA_W-1 -: RA_W];

    assign bus.inst_ready = (state == ST_FETCH);
    assign busy           = (state != ST_FETCH);
    assign bus.leds       = leds_q;
    assign bus.led_valid  = led_valid_q;

    core_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .func   (func_q),
        .result (alu_res),
        .c      (alu_c),
        .z      (alu_z)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_FETCH;
            inst_q      <= '0;
            op_q        <= '0;
            rx_q        <= '0;
            func_q      <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            leds_q      <= '0;
            led_valid_q <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            retired     <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            led_valid_q <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (bus.inst_valid) begin
                        inst_q <= bus.inst;
                        state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Register file is read here, after the previous EXECUTE committed.
                    op_q   <= inst_q[INST_W-1 -: 2];
                    rx_q   <= rx_d;
                    func_q <= inst_q[1:0];
                    imm_q  <= inst_q[DATA_W-1:0];
                    a_q    <= regs[rx_d];
                    b_q    <= regs[ry_d];
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_LOAD:  regs[rx_q] <= imm_q;
                        OP_STORE: begin
                            leds_q      <= a_q;
                            led_valid_q <= 1'b1;
                        end
                        OP_MOVE:  regs[rx_q] <= b_q;
                        default: begin
                            regs[rx_q] <= alu_res;
                            flag_c     <= alu_c;
                            flag_z     <= alu_z;
                        end
                    endcase
                    retired <= retired + CNT_W'(1);
                    state   <= ST_FETCH;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_param_core.sv
// Directed bench: default-config core (a) plus an 8-bit/8-register core with 4-bit counter (b).
module tb_param_core;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    param_core_if #(.DATA_W(4), .NREG(4)) bus_a ();
    param_core_if #(.DATA_W(8), .NREG(8)) bus_b ();

    logic        z_a, c_a, busy_a;
    logic [15:0] ret_a;
    logic        z_b, c_b, busy_b;
    logic [3:0]  ret_b;

    param_core u_a (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus_a),
        .flag_z  (z_a),
        .flag_c  (c_a),
        .retired (ret_a),
        .busy    (busy_a)
    );

    param_core #(.DATA_W(8), .NREG(8), .CNT_W(4)) u_b (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus_b),
        .flag_z  (z_b),
        .flag_c  (c_b),
        .retired (ret_b),
        .busy    (busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the EXECUTE edge.
    task automatic issue_a(input logic [7:0] i);
        int w = 0;
        while (!bus_a.inst_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!bus_a.inst_ready) check_eq("a_ready_timeout", 0, 1);
        bus_a.inst       = i;
        bus_a.inst_valid = 1'b1;
        @(negedge clk);
        bus_a.inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic issue_b(input logic [12:0] i);
        int w = 0;
        while (!bus_b.inst_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!bus_b.inst_ready) check_eq("b_ready_timeout", 0, 1);
        bus_b.inst       = i;
        bus_b.inst_valid = 1'b1;
        @(negedge clk);
        bus_b.inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    int accepts;

    initial begin
        clr              = 1'b1;
        bus_a.inst       = '0;
        bus_a.inst_valid = 1'b0;
        bus_b.inst       = '0;
        bus_b.inst_valid = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;

        check_eq("rst_leds", bus_a.leds, 0);
        check_eq("rst_led_valid", bus_a.led_valid, 0);
        check_eq("rst_flags", {z_a, c_a}, 0);
        check_eq("rst_retired", ret_a, 0);
        check_eq("rst_ready", bus_a.inst_ready, 1);
        check_eq("rst_busy", busy_a, 0);

        // LOAD R1,7 ; STORE R1
        issue_a(8'h17);
        issue_a(8'h50);
        check_eq("st_leds", bus_a.leds, 4'h7);
        check_eq("st_led_valid", bus_a.led_valid, 1);
        check_eq("st_retired", ret_a, 2);
        check_eq("st_flags", {z_a, c_a}, 0);
        @(negedge clk);
        check_eq("st_led_valid_drop", bus_a.led_valid, 0);

        // 0xF + 2 -> 1 with carry
        issue_a(8'h0F);
        issue_a(8'h12);
        issue_a(8'hC4);
        check_eq("add_flags", {z_a, c_a}, 2'b01);
        issue_a(8'h40);
        check_eq("add_leds", bus_a.leds, 4'h1);
        check_eq("add_retired", ret_a, 6);

        // 3 - 5 -> 0xE with borrow; R3 - R3 -> 0; MOVE keeps flags
        issue_a(8'h23);
        issue_a(8'h35);
        issue_a(8'hED);
        check_eq("sub_flags", {z_a, c_a}, 2'b01);
        issue_a(8'h60);
        check_eq("sub_leds", bus_a.leds, 4'hE);
        check_eq("store_keeps_flags", {z_a, c_a}, 2'b01);
        issue_a(8'hFD);
        check_eq("subself_flags", {z_a, c_a}, 2'b10);
        issue_a(8'h8C);
        check_eq("move_keeps_flags", {z_a, c_a}, 2'b10);
        issue_a(8'h40);
        check_eq("move_leds", bus_a.leds, 4'h0);

        // 0xC & 0xA -> 8
        issue_a(8'h1C);
        issue_a(8'h2A);
        issue_a(8'hDA);
        check_eq("and_flags", {z_a, c_a}, 2'b00);
        issue_a(8'h50);
        check_eq("and_leds", bus_a.leds, 4'h8);
        check_eq("and_retired", ret_a, 17);

        // Idle: nothing moves
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("idle_ready", bus_a.inst_ready, 1);
        end
        check_eq("idle_retired", ret_a, 17);

        // LOAD R1,3 with a stray valid (LOAD R1,F) held through DECODE
        bus_a.inst       = 8'h13;
        bus_a.inst_valid = 1'b1;
        @(negedge clk);
        bus_a.inst = 8'h1F;
        check_eq("dec_ready", bus_a.inst_ready, 0);
        check_eq("dec_busy", busy_a, 1);
        @(negedge clk);
        check_eq("exe_ready", bus_a.inst_ready, 0);
        bus_a.inst_valid = 1'b0;
        @(negedge clk);
        check_eq("stray_retired", ret_a, 18);
        issue_a(8'h50);
        check_eq("stray_leds", bus_a.leds, 4'h3);

        // Continuous stream of LOAD R0,0: one accept every 3 cycles
        accepts          = 0;
        bus_a.inst       = 8'h00;
        bus_a.inst_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (bus_a.inst_ready) accepts++;
            @(negedge clk);
        end
        bus_a.inst_valid = 1'b0;
        check_eq("stream_accepts", accepts, 3);
        check_eq("stream_retired", ret_a, 22);

        // clr during EXECUTE of LOAD R1,9
        bus_a.inst       = 8'h19;
        bus_a.inst_valid = 1'b1;
        @(negedge clk);
        bus_a.inst_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("clr_retired", ret_a, 0);
        check_eq("clr_leds", bus_a.leds, 0);
        check_eq("clr_flags", {z_a, c_a}, 0);
        check_eq("clr_ready", bus_a.inst_ready, 1);
        check_eq("clr_led_valid", bus_a.led_valid, 0);
        bus_a.inst       = 8'h50;
        bus_a.inst_valid = 1'b1;
        @(negedge clk);
        bus_a.inst_valid = 1'b0;
        check_eq("clr_accept", bus_a.inst_ready, 0);
        @(negedge clk);
        @(negedge clk);
        check_eq("clr_r1_leds", bus_a.leds, 4'h0);
        check_eq("clr_r1_valid", bus_a.led_valid, 1);
        check_eq("clr_retired_after", ret_a, 1);

        // Wide core: 0xA5 + 0x5B -> 0x00, c=1, z=1 (b was also reset above)
        issue_b(13'h00A5);
        issue_b(13'h015B);
        issue_b(13'h1820);
        check_eq("b_add_flags", {z_b, c_b}, 2'b11);
        issue_b(13'h0800);
        check_eq("b_add_leds", bus_b.leds, 8'h00);
        check_eq("b_add_valid", bus_b.led_valid, 1);
        issue_b(13'h0900);
        check_eq("b_r1_leds", bus_b.leds, 8'h5B);
        for (int k = 0; k < 10; k++) issue_b(13'h0200 | 13'(k));
        check_eq("b_retired_max", ret_b, 4'hF);
        issue_b(13'h0000);
        check_eq("b_retired_wrap", ret_b, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/param_core.md
# param_core

Parametrised register-file processor core that generalises the 4-bit fetch/decode/execute datapath to configurable data width and register count. It adds a valid/ready instruction handshake, explicit FSM states, ALU carry/zero flags, a store-valid strobe and a retired-instruction counter. It sits between the instruction sources (switch bank or instruction ROM, muxed upstream) and the LED output. With default parameters its 8-bit instruction encoding is identical to the existing core.

## Interface
- DATA_W, 4: register/ALU/LED width; must satisfy DATA_W >= RA_W + 2
- NREG, 4: number of registers, power of two, >= 2
- RA_W, $clog2(NREG): register address width (derived, not overridden)
- INST_W, 2 + RA_W + DATA_W: instruction width (derived)
- CNT_W, 16: retired-instruction counter width
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset; synchronous, active-high
- inst  in  INST_W  instruction {op[1:0], rx[RA_W-1:0], operand[DATA_W-1:0]}
- inst_valid  in  1  inst is valid this cycle
- inst_ready  out  1  core accepts inst this cycle (also used as ROM step request)
- leds  out  DATA_W  output register written by store
- led_valid  out  1  one-cycle pulse when leds was written
- flag_z  out  1  last ALU result was zero
- flag_c  out  1  last ALU carry (add) / borrow (sub)
- retired  out  CNT_W  count of executed instructions
- busy  out  1  high in DECODE and EXECUTE

## Operation
- Fields: ry = operand[DATA_W-1 -: RA_W]; func = operand[1:0]; imm = operand.
- op 00 LOAD: r[rx] <= imm.
- op 01 STORE: leds <= r[rx]; led_valid pulses.
- op 10 MOVE: r[rx] <= r[ry].
- op 11 ALU, by func: 00 add: {c, r[rx]} <= r[rx] + r[ry]. 01 sub: r[rx] <= r[rx] - r[ry] mod 2^DATA_W, c = (r[rx] < r[ry]). 10 and: c = 0. 11 not: r[rx] <= ~r[rx], c = 0.
- Flags are updated only by ALU ops; z = (result == 0). LOAD, STORE and MOVE leave flags unchanged.
- rx == ry is legal. Operands are read before the write: sub of a register with itself gives 0, z=1, c=0.
- FSM, three states:
  - FETCH: inst_ready=1. On inst_valid, latch inst and go to DECODE; otherwise stay.
  - DECODE: latch op, rx, ry, func, imm, and both register operands. Go to EXECUTE.
  - EXECUTE: perform the write, leds and flag updates; retired += 1 (wraps at 2^CNT_W). Go to FETCH.
- inst_valid is ignored outside FETCH. There is no back-pressure on leds.
- Reset (clr) values: state FETCH; all r[] = 0; leds = 0; led_valid = 0; flag_z = 0; flag_c = 0; retired = 0; latched instruction = 0. clr overrides any in-flight instruction, which is discarded with no partial write.

## Timing
- Accept edge T (FETCH with inst_valid=1). DECODE in cycle T+1. EXECUTE updates registers at edge T+2.
- Results, flags, leds and retired are visible after edge T+2. led_valid is high for the single cycle following edge T+2.
- inst_ready is 0 in the cycles after edges T and T+1, and 1 again after T+2. Throughput is one instruction per 3 cycles at most.
- Back-to-back dependent instructions need no forwarding: DECODE reads the register file after the previous EXECUTE has committed.
- All outputs are registered except inst_ready and busy, which are decoded from the state register only.

## Structure
- Shared package core_pkg holds:
  - opcode localparams OP_LOAD, OP_STORE, OP_MOVE, OP_ALU
  - func localparams FN_ADD, FN_SUB, FN_AND, FN_NOT
  - FSM state encoding ST_FETCH, ST_DECODE, ST_EXEC
- One sub-module, core_alu: combinational, parametrised by DATA_W. Inputs: a, b, func. Outputs: result, c, z.
- The register file is an in-module array of NREG x DATA_W with one write port and two read ports.

## Test plan
- Defaults. LOAD R1,7 (0x17), then STORE R1 (0x50) -> leds=0x7, led_valid high for exactly 1 cycle, retired=2, flags 0.
- LOAD R0,0xF (0x0F), LOAD R1,2 (0x12), ADD R0,R1 (0xC4), STORE R0 (0x40) -> leds=0x1, flag_c=1, flag_z=0.
- LOAD R2,3 (0x23), LOAD R3,5 (0x35), SUB R2,R3 (0xED) -> R2=0xE, c=1. Then SUB R3,R3 (0xFD) -> R3=0, z=1, c=0. Then MOVE R0,R3 (0x8C) -> flags unchanged.
- Handshake:
  - inst_valid low for 5 cycles -> no state change, inst_ready stays 1.
  - inst_valid pulsed during DECODE -> ignored, retired unchanged.
  - A continuous valid stream -> exactly one accept every 3 cycles.
- Reset: assert clr in the cycle before the EXECUTE edge of LOAD R1,9 -> R1 stays 0, all outputs at reset values, next accept in the cycle after clr deasserts.
- DATA_W=8, NREG=8 (INST_W=13): LOAD R0,0xA5; LOAD R1,0x5B; ADD R0,R1 -> R0=0x00, c=1, z=1. Then preset retired to all-ones via CNT_W=4 and 16 instructions -> wraps to 0.
